// File: rtl/simon_pkt_out_if.sv
// simon_pkt_out_if: core-result handshake plus packet FIFO output port.
// slave is the packetiser's view, master is the core/consumer side.
interface simon_pkt_out_if #(
   parameter int N = 48,
   parameter int BLOCKS = 2,
   parameter int DEPTH = 4
);
   localparam int PB = 16 + 2 * BLOCKS * N;
   localparam int LW = $clog2(DEPTH + 1);

   logic                done_data_unused_guard;
   logic                doneDATA;
   logic [7:0]          infoOUT;
   logic [1:0][N-1:0]   outDATA;
   logic                readDATA;
   logic                out_donePKT;
   logic                out_readPKT;
   logic [PB-1:0]       out;
   logic [LW-1:0]       level;
   logic                err;

   assign done_data_unused_guard = 1'b0;

   modport slave (
      input  doneDATA, infoOUT, outDATA, out_readPKT,
      output readDATA, out_donePKT, out, level, err
   );

   modport master (
      output doneDATA, infoOUT, outDATA, out_readPKT,
      input  readDATA, out_donePKT, out, level, err
   );
endinterface

// File: rtl/simon_pkt_out.sv
// simon_pkt_out: packs SIMON result blocks into packets held in a DEPTH-entry FIFO.
// Define SIMON_OUT_CHECK_EN to drop packets with a bad mode/direction and flag err.
module simon_pkt_out #(
   parameter int N = 48,
   parameter int BLOCKS = 2,
   parameter int DEPTH = 4,
   parameter int MODE = 4'h3
) (
   input logic            clk,
   input logic            nR,
   simon_pkt_out_if.slave bus
);
   localparam int PB = 16 + 2 * BLOCKS * N;
   localparam int BW = $clog2(BLOCKS + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [BW-1:0] LAST = BW'(BLOCKS - 1);

   if (N % 8 != 0 || BLOCKS < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       MODE < 0 || MODE > 15) begin : g_bad_cfg
      $error("simon_pkt_out: illegal parameters");
   end

   typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;

   state_t                     st, nxt;
   logic [7:0]                 info_q, cur_info, count;
   logic [BW-1:0]              b, idx;
   logic [2*BLOCKS-1:0][N-1:0] words;
   logic [N-1:0]               lo, hi;
   logic [AW-1:0]              wp, rp;
   logic [LW-1:0]              lvl;
   logic [PB-1:0]              mem [DEPTH];
   logic                       rd, full, can_cap, cap, push, pop, first, bad;

   assign full    = lvl == LW'(DEPTH);
   assign can_cap = bus.doneDATA & ~rd & ~full;
   assign pop     = (lvl != '0) & bus.out_readPKT;
   assign idx     = (st == IDLE) ? '0 : b;

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) st <= IDLE;
      else     st <= nxt;
   end

   always_comb begin
      nxt      = st;
      cap      = 1'b0;
      first    = 1'b0;
      push     = 1'b0;
      cur_info = info_q;
      unique case (st)
         IDLE: begin
            cur_info = bus.infoOUT;
            cap      = can_cap;
            first    = can_cap;
            if (can_cap)
               nxt = (bus.infoOUT[7] && BLOCKS > 1) ? COLLECT : PUSH;
         end
         COLLECT: begin
            cap = can_cap;
            if (can_cap && b == LAST) nxt = PUSH;
         end
         PUSH: begin
            push = ~bad;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // word[2b] takes the unswapped upper word; key packets carry no data
   always_comb begin
      lo = cur_info[6] ? bus.outDATA[0] : bus.outDATA[1];
      hi = cur_info[6] ? bus.outDATA[1] : bus.outDATA[0];
      if (cur_info[5]) begin
         lo = '0;
         hi = '0;
      end
   end

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         rd     <= 1'b0;
         info_q <= '0;
         b      <= '0;
         words  <= '0;
         count  <= '0;
      end else begin
         rd <= cap;
         if (st == PUSH) begin
            words <= '0;
            b     <= '0;
            if (!bad) count <= count + 8'd1;
         end
         if (cap) begin
            if (st == IDLE) begin
               info_q <= bus.infoOUT;
               b      <= BW'(1);
            end else begin
               b <= b + BW'(1);
            end
            for (int i = 0; i < BLOCKS; i++) begin
               if (idx == BW'(i)) begin
                  words[2*i]   <= lo;
                  words[2*i+1] <= hi;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {info_q, count, words};
   end

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         wp  <= '0;
         rp  <= '0;
         lvl <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         unique case ({push, pop})
            2'b10:   lvl <= lvl + LW'(1);
            2'b01:   lvl <= lvl - LW'(1);
            default: lvl <= lvl;
         endcase
      end
   end

`ifdef SIMON_OUT_CHECK_EN
   logic bad_q, err_q, bad_now;

   assign bad_now = (bus.infoOUT[3:0] != 4'(MODE)) | ~bus.infoOUT[4];

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         bad_q <= 1'b0;
         err_q <= 1'b0;
      end else if (first) begin
         bad_q <= bad_now;
         if (bad_now) err_q <= 1'b1;
      end
   end

   assign bad     = bad_q;
   assign bus.err = err_q;
`else
   assign bad     = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.readDATA    = rd;
   assign bus.out_donePKT = lvl != '0;
   assign bus.level       = lvl;
   assign bus.out         = (lvl != '0) ? mem[rp] : '0;
endmodule

// File: tb/tb_simon_pkt_out.sv
// tb_simon_pkt_out: directed packets with a scoreboard queue checked at the
// output handshake, plus direct checks of timing, backpressure and reset.
module tb_simon_pkt_out;
   localparam int N = 48;
   localparam int BLOCKS = 2;
   localparam int DEPTH = 4;
   localparam int PB = 16 + 2 * BLOCKS * N;

   logic clk = 1'b0;
   logic nR;
   int   checks = 0;
   int   errors = 0;
   int   acks = 0;
   logic [7:0] cnt;
   logic [PB-1:0] sbq[$];
   logic [PB-1:0] expd;

   simon_pkt_out_if #(.N(N), .BLOCKS(BLOCKS), .DEPTH(DEPTH)) bus ();

   simon_pkt_out #(.N(N), .BLOCKS(BLOCKS), .DEPTH(DEPTH), .MODE(4'h3)) dut (
      .clk(clk),
      .nR (nR),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [PB-1:0] mk(input logic [7:0] inf, input logic [7:0] c,
      input logic [N-1:0] w3, w2, w1, w0);
      return {inf, c, w3, w2, w1, w0};
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] inf, input logic [N-1:0] d1, d0,
      input int budget, output bit ok);
      bus.doneDATA = 1'b1;
      bus.infoOUT  = inf;
      bus.outDATA  = {d1, d0};
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk);
         #1;
         if (bus.readDATA) ok = 1'b1;
      end
      bus.doneDATA = 1'b0;
   endtask

   task automatic drain(input string nm);
      bus.out_readPKT = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 50 && bus.level != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk(nm, bus.level, 0);
      bus.out_readPKT = 1'b0;
   endtask

   task automatic do_reset();
      nR = 1'b0;
      sbq.delete();
      cnt = 8'd0;
      @(posedge clk);
      #1;
      nR = 1'b1;
   endtask

   always @(negedge clk) begin
      if (nR && bus.readDATA) acks++;
      if (nR && bus.out_donePKT && bus.out_readPKT) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL pkt_extra: got %h expected none", bus.out);
         end else begin
            expd = sbq.pop_front();
            if (bus.out !== expd) begin
               errors++;
               $display("FAIL pkt: got %h expected %h", bus.out, expd);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int a0;
      logic [N-1:0] d1, d0;
      nR = 1'b0;
      cnt = 8'd0;
      bus.doneDATA = 1'b0;
      bus.infoOUT = '0;
      bus.outDATA = '0;
      bus.out_readPKT = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_read", bus.readDATA, 0);
      chk("rst_done", bus.out_donePKT, 0);
      chk("rst_out", bus.out, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_err", bus.err, 0);
      nR = 1'b1;
      @(posedge clk);
      #1;

      // single block, no swap, 2-cycle latency
      sbq.push_back(mk(8'h13, cnt, 0, 0, 48'h555555555555, 48'hAAAAAAAAAAAA));
      cnt++;
      send(8'h13, 48'hAAAAAAAAAAAA, 48'h555555555555, 20, ok);
      chk("t1_ack", ok, 1);
      chk("t1_done_e1", bus.out_donePKT, 0);
      @(posedge clk);
      #1;
      chk("t1_done_e2", bus.out_donePKT, 1);
      chk("t1_level", bus.level, 1);
      drain("t1_drain");

      // multiblock with swap, then a following single block
      sbq.push_back(mk(8'hD3, cnt, 48'h333333333333, 48'h444444444444,
                       48'h111111111111, 48'h222222222222));
      cnt++;
      send(8'hD3, 48'h111111111111, 48'h222222222222, 20, ok);
      chk("t2_ack0", ok, 1);
      send(8'hD3, 48'h333333333333, 48'h444444444444, 20, ok);
      chk("t2_ack1", ok, 1);
      sbq.push_back(mk(8'h13, cnt, 0, 0, 48'h666666666666, 48'h777777777777));
      cnt++;
      send(8'h13, 48'h777777777777, 48'h666666666666, 20, ok);
      chk("t2_ack2", ok, 1);
      drain("t2_drain");

      // key packet
      a0 = acks;
      sbq.push_back(mk(8'h33, cnt, 0, 0, 0, 0));
      cnt++;
      send(8'h33, 48'hDEADBEEF0123, 48'h456789ABCDEF, 20, ok);
      chk("t3_ack", ok, 1);
      drain("t3_drain");
      chk("t3_pulses", acks - a0, 1);

      // backpressure
      for (int k = 0; k < 4; k++) begin
         d1 = 48'h100000000000 + 48'(k);
         d0 = 48'h200000000000 + 48'(k);
         sbq.push_back(mk(8'h13, cnt, 0, 0, d0, d1));
         cnt++;
         send(8'h13, d1, d0, 20, ok);
         chk("t4_ack", ok, 1);
      end
      d1 = 48'h0F0F0F0F0F0F;
      d0 = 48'hF0F0F0F0F0F0;
      send(8'h13, d1, d0, 10, ok);
      chk("t4_stall", ok, 0);
      chk("t4_full", bus.level, 4);
      sbq.push_back(mk(8'h13, cnt, 0, 0, d0, d1));
      cnt++;
      bus.doneDATA = 1'b1;
      bus.out_readPKT = 1'b1;
      @(posedge clk);
      #1;
      bus.out_readPKT = 1'b0;
      for (int i = 0; i < 10 && !bus.readDATA; i++) begin
         @(posedge clk);
         #1;
      end
      chk("t4_ack5", bus.readDATA, 1);
      bus.doneDATA = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_refill", bus.level, 4);
      drain("t4_drain");

      // count wrap over 257 packets
      do_reset();
      bus.out_readPKT = 1'b1;
      for (int i = 0; i < 257; i++) begin
         d1 = {16'hC0DE, 32'(i)};
         d0 = ~d1;
         sbq.push_back(mk(8'h13, cnt, 0, 0, d0, d1));
         cnt++;
         send(8'h13, d1, d0, 20, ok);
         if (!ok) chk("t5_ack", ok, 1);
      end
      drain("t5_drain");

      // reset in COLLECT
      sbq.push_back(mk(8'h13, cnt, 0, 0, 48'h1, 48'h2));
      cnt++;
      send(8'h13, 48'h2, 48'h1, 20, ok);
      send(8'hD3, 48'h999999999999, 48'h888888888888, 20, ok);
      chk("t6_ack", ok, 1);
      nR = 1'b0;
      #1;
      chk("t6_level", bus.level, 0);
      chk("t6_done", bus.out_donePKT, 0);
      chk("t6_out", bus.out, 0);
      chk("t6_read", bus.readDATA, 0);
      sbq.delete();
      cnt = 8'd0;
      @(posedge clk);
      #1;
      nR = 1'b1;
      sbq.push_back(mk(8'h13, cnt, 0, 0, 48'hABCDEF012345, 48'h543210FEDCBA));
      cnt++;
      send(8'h13, 48'h543210FEDCBA, 48'hABCDEF012345, 20, ok);
      chk("t6_ack2", ok, 1);
      drain("t6_drain");

      // mode/direction check
      a0 = acks;
`ifdef SIMON_OUT_CHECK_EN
      send(8'h03, 48'h123456789ABC, 48'hCBA987654321, 20, ok);
      chk("t7_ack", ok, 1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("t7_level", bus.level, 0);
      chk("t7_done", bus.out_donePKT, 0);
      chk("t7_err", bus.err, 1);
      chk("t7_pulses", acks - a0, 1);
      sbq.push_back(mk(8'h13, cnt, 0, 0, 48'h5, 48'h6));
      cnt++;
      send(8'h13, 48'h6, 48'h5, 20, ok);
      drain("t7_drain");
      chk("t7_err_hold", bus.err, 1);
`else
      sbq.push_back(mk(8'h03, cnt, 0, 0, 48'hCBA987654321, 48'h123456789ABC));
      cnt++;
      send(8'h03, 48'h123456789ABC, 48'hCBA987654321, 20, ok);
      chk("t7_ack", ok, 1);
      drain("t7_drain");
      chk("t7_err", bus.err, 0);
      chk("t7_pulses", acks - a0, 1);
`endif

      chk("sb_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/simon_pkt_out.md
# simon_pkt_out

Parametrised output packetiser for the SIMON datapath. It takes result blocks from the cipher core over a level/acknowledge handshake and assembles them into packets of 1 to BLOCKS blocks. Each packet carries an info byte, an 8-bit sequence count and the block data. Completed packets are buffered in a DEPTH-entry packet FIFO ahead of the output port, which replaces single-packet, edge-triggered output buffering with a fully synchronous, back-pressured path.

## Interface
- N, 48, cipher word width in bits; must be a multiple of 8.
- BLOCKS, 2, maximum blocks per packet; must be 1 or more.
- DEPTH, 4, packet FIFO depth; must be a power of 2 and 2 or more.
- MODE, 4'h3, expected mode code in info[3:0].
- clk  in  1  clock; all logic on the rising edge.
- nR  in  1  reset, asynchronous, active-low.
- doneDATA  in  1  core result valid; level, held until acknowledged.
- infoOUT  in  8  info byte for the current result.
- outDATA  in  2×N  result block, words [1] and [0].
- readDATA  out  1  one-cycle registered acknowledge of a captured result.
- out_donePKT  out  1  FIFO head valid (FIFO not empty).
- out_readPKT  in  1  consumer accepts the head packet.
- out  out  (2+2·BLOCKS·N/8)×8  head packet: {info, count, word[2·BLOCKS−1] … word[0]}.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- err  out  1  sticky mode or direction error.

## Operation
- Info byte fields:
  - [3:0] mode.
  - [4] output-direction flag (must be 1).
  - [5] key packet: data is forced to zero.
  - [6] word swap.
  - [7] multiblock: packet length is BLOCKS, otherwise 1.
- Capture condition: doneDATA=1, readDATA=0 and the FIFO is not full. Each capture raises readDATA for exactly one cycle. The core must drop doneDATA, or present the next result, in that cycle.
- FSM states: IDLE, COLLECT, PUSH.
  - IDLE: on capture, latch infoOUT and set target = info[7] ? BLOCKS : 1, with block index b=0. Go to PUSH if target=1, else COLLECT.
  - COLLECT: each capture stores the block at index b. Go to PUSH when b reaches target−1.
  - PUSH: write the packet into the FIFO, increment count, clear the assembly buffer, go to IDLE. No capture occurs in this state.
- Block store at index b:
  - word[2b] = outDATA[~info[6]]
  - word[2b+1] = outDATA[info[6]]
  - When info[5]=1, both words are zero.
- Blocks not filled stay zero. infoOUT on captures after the first is ignored.
- count: 8-bit. The packet carries the pre-increment value. Wraps from 255 to 0.
- FIFO pop: occurs when out_donePKT && out_readPKT. A push and a pop in the same cycle leave level unchanged.
- Full FIFO: captures stall, and readDATA stays 0 until a pop. Because a push always follows a capture that was allowed under the not-full rule, no overflow is possible.
- Reset, at any time:
  - FSM goes to IDLE, the partial packet is discarded, the FIFO empties and count becomes 0.
  - Outputs: readDATA=0, out_donePKT=0, out=0, level=0, err=0.

## Timing
- doneDATA seen before edge E (capture), for the final block of a packet:
  - readDATA=1 in cycle E..E+1.
  - Push at edge E+1.
  - out_donePKT=1 from edge E+1, i.e. 2 cycles latency into an empty FIFO.
- Maximum throughput is one capture every 2 cycles. A single-block packet costs 2 cycles, since the PUSH cycle overlaps the readDATA-high cycle.
- out and out_donePKT are combinational from FIFO registers. The next head appears in the cycle after a pop.
- level updates on the edge of each push or pop.

## Configuration
- SIMON_OUT_CHECK_EN defined:
  - At the first capture of a packet, check infoOUT[3:0]==MODE and infoOUT[4]==1.
  - On mismatch, all of the packet's results are still captured and acknowledged, but nothing is pushed, count is not incremented, and err sets and holds until reset.
- SIMON_OUT_CHECK_EN undefined:
  - No checks; err is tied to 0.
  - Every packet is pushed regardless of info.

## Test plan
- Single block, swap off:
  - Stimulus: defaults, info=0x13, outDATA[1]=0xAAAAAAAAAAAA, outDATA[0]=0x555555555555.
  - Response: after 2 cycles out_donePKT=1, out[25]=0x13, out[24]=0x00, word[0]=0xAAAA…, word[1]=0x5555…, words 2–3 zero.
- Multiblock with swap:
  - Stimulus: info=0xD3, two results R0 then R1.
  - Response: one packet with count=0x00; word[0]=R0[0], word[1]=R0[1], word[2]=R1[0], word[3]=R1[1]. The next packet carries count=0x01.
- Key packet:
  - Stimulus: info=0x33 with nonzero outDATA.
  - Response: packet info=0x33 with all data bytes 0x00; one readDATA pulse.
- Backpressure:
  - Stimulus: out_readPKT=0, offer 5 single-block packets.
  - Response: level=4, the 5th result is not acknowledged and readDATA stays 0. Raising out_readPKT for one cycle lets the 5th be captured, and level returns to 4.
- Wrap and reset:
  - 257 packets: counts run 0x00 … 0xFF, 0x00.
  - Reset asserted in COLLECT after 1 of 2 blocks: level=0, out_donePKT=0, and the next packet carries count 0x00.
- Checking (SIMON_OUT_CHECK_EN):
  - info=0x03 (bit4 clear): result is acknowledged, no packet is produced, err=1 and held.
  - Without the macro, the same stimulus yields a packet with info=0x03 and err=0.
